// File: rtl/button_event_fsm_pkg.sv
// Shared state encodings and default cycle constants for the button event FSM.
package button_event_fsm_pkg;

  localparam int unsigned CNT_W_DEF         = 8;
  localparam int unsigned TMR_W_DEF         = 26;
  localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;  // 1 s at 50 MHz
  localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;  // 200 ms at 50 MHz

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESS    = 2'd1,
    S_LONG     = 2'd2,
    S_WAIT_REL = 2'd3
  } state_t;

  // States in which the button counts as held by a single accepted press
  function automatic logic is_held(input state_t s);
    return (s == S_PRESS) || (s == S_LONG);
  endfunction

endpackage

// File: rtl/button_event_fsm_timer.sv
// event_timer: clearable up-counter with a terminal-count compare.
module event_timer #(
  parameter int unsigned W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done_c
);

  logic [W-1:0] count;

  // Clear has priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign done_c = (count == term);

endmodule

// File: rtl/button_event_fsm.sv
// Button event FSM: turns debounced level/valid into press, release, long-press
// (and optional auto-repeat) pulses plus a wrapping press counter.
// Optional feature: define BTN_AUTO_REPEAT_EN to enable auto-repeat in S_LONG.
module button_event_fsm
  import button_event_fsm_pkg::*;
#(
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned TMR_W         = TMR_W_DEF,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_level,
  input  logic             sw_valid,
  input  logic             cnt_clr,
  output logic             press,
  output logic             release_evt,
  output logic             long_press,
  output logic             repeat_evt,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  state_t           state_q, state_d;
  logic             press_d, rel_d, long_d;
  logic [CNT_W-1:0] cnt_d;
  logic             hold_clr, hold_en, hold_done;

  // Hold timer: zeroed in idle, counts while pressed, stops at LONG_CYCLES-1
  event_timer #(.W(TMR_W)) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (hold_clr),
    .en     (hold_en),
    .term   (TMR_W'(LONG_CYCLES - 1)),
    .done_c (hold_done)
  );

`ifdef BTN_AUTO_REPEAT_EN
  logic rpt_d, rpt_clr, rpt_done;

  // Repeat timer: free-runs only while staying in S_LONG, restarts on terminal
  event_timer #(.W(TMR_W)) u_repeat_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rpt_clr),
    .en     (1'b1),
    .term   (TMR_W'(REPEAT_CYCLES - 1)),
    .done_c (rpt_done)
  );
`else
  logic unused_rpt;
  assign unused_rpt = ^REPEAT_CYCLES;
  assign repeat_evt = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      held        <= 1'b0;
      press_count <= '0;
`ifdef BTN_AUTO_REPEAT_EN
      repeat_evt  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      press       <= press_d;
      release_evt <= rel_d;
      long_press  <= long_d;
      held        <= is_held(state_d);
      press_count <= cnt_d;
`ifdef BTN_AUTO_REPEAT_EN
      repeat_evt  <= rpt_d;
`endif
    end
  end

  // Next-state, event and timer-control decode; release always beats long/repeat
  always_comb begin
    state_d  = state_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    long_d   = 1'b0;
    hold_clr = 1'b0;
    hold_en  = 1'b0;
    cnt_d    = cnt_clr ? '0 : press_count;
`ifdef BTN_AUTO_REPEAT_EN
    rpt_d    = 1'b0;
    rpt_clr  = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        hold_clr = 1'b1;
        if (sw_valid && sw_level) begin
          state_d = S_PRESS;
          press_d = 1'b1;
          cnt_d   = cnt_d + CNT_W'(1);
        end
      end
      S_PRESS: begin
        if (sw_valid) begin
          if (!sw_level) begin
            state_d = S_IDLE;
            rel_d   = 1'b1;
          end else begin
            state_d = S_WAIT_REL;
          end
        end else if (hold_done) begin
          state_d = S_LONG;
          long_d  = 1'b1;
        end else begin
          hold_en = 1'b1;
        end
      end
      S_LONG: begin
        if (sw_valid) begin
          if (!sw_level) begin
            state_d = S_IDLE;
            rel_d   = 1'b1;
          end else begin
            state_d = S_WAIT_REL;
          end
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          rpt_clr = rpt_done;
          rpt_d   = rpt_done;
`endif
        end
      end
      S_WAIT_REL: begin
        if (sw_valid && !sw_level) begin
          state_d = S_IDLE;
          rel_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_event_fsm.sv
// Self-checking bench for button_event_fsm: vector table, directed corner
// sequences and random traffic against a timestamp-based reference model.
module tb_button_event_fsm;

  localparam int unsigned CNT_W = 4;
  localparam int          LONG  = 20;
  localparam int          RPT   = 5;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  typedef struct packed {
    logic             press;
    logic             rel;
    logic             lng;
    logic             rpt;
    logic             held;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct {
    logic v;
    logic l;
    logic c;
    obs_t exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sw_level, sw_valid, cnt_clr;
  logic             press, release_evt, long_press, repeat_evt, held;
  logic [CNT_W-1:0] press_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: accepted-press bookkeeping plus press timestamp
  bit               m_active, m_wait;
  int               m_press_cyc;
  logic [CNT_W-1:0] m_cnt;
  obs_t             m_exp;

  button_event_fsm #(
    .CNT_W         (CNT_W),
    .TMR_W         (26),
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (RPT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw_level    (sw_level),
    .sw_valid    (sw_valid),
    .cnt_clr     (cnt_clr),
    .press       (press),
    .release_evt (release_evt),
    .long_press  (long_press),
    .repeat_evt  (repeat_evt),
    .held        (held),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  function automatic obs_t dut_obs();
    obs_t o;
    o.press = press;
    o.rel   = release_evt;
    o.lng   = long_press;
    o.rpt   = repeat_evt;
    o.held  = held;
    o.cnt   = press_count;
    return o;
  endfunction

  function automatic vec_t mk(input logic v, l, c, p, r, lg, h, input int cnt);
    vec_t t;
    t.v = v; t.l = l; t.c = c;
    t.exp.press = p; t.exp.rel = r; t.exp.lng = lg; t.exp.rpt = 1'b0;
    t.exp.held = h; t.exp.cnt = CNT_W'(cnt);
    return t;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @cyc%0d: got p%0b r%0b l%0b rp%0b h%0b cnt%0d, want p%0b r%0b l%0b rp%0b h%0b cnt%0d",
               name, cyc, got.press, got.rel, got.lng, got.rpt, got.held, got.cnt,
               want.press, want.rel, want.lng, want.rpt, want.held, want.cnt);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s @cyc%0d: got %0d, want %0d", name, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_wait   = 1'b0;
    m_cnt    = '0;
    m_exp    = '0;
  endtask

  // Expected outputs after a clock edge with inputs (v,l,c)
  task automatic model_edge(input logic v, l, c);
    int age;
    m_exp = '0;
    if (v && l) begin
      if (!m_active && !m_wait) begin
        m_exp.press = 1'b1;
        m_active    = 1'b1;
        m_press_cyc = cyc;
        m_cnt       = c ? CNT_W'(1) : m_cnt + CNT_W'(1);
      end else if (m_active) begin
        m_active = 1'b0;
        m_wait   = 1'b1;
      end
    end else if (v && !l) begin
      if (m_active || m_wait) m_exp.rel = 1'b1;
      m_active = 1'b0;
      m_wait   = 1'b0;
    end else if (m_active) begin
      age = cyc - m_press_cyc;
      if (age == LONG) m_exp.lng = 1'b1;
      if (RPT_EN && age > LONG && ((age - LONG) % RPT) == 0) m_exp.rpt = 1'b1;
    end
    if (c && !m_exp.press) m_cnt = '0;
    m_exp.held = m_active;
    m_exp.cnt  = m_cnt;
  endtask

  // One clock with given inputs, then compare DUT against the model
  task automatic step(input logic v, l, c);
    sw_valid = v;
    sw_level = l;
    cnt_clr  = c;
    @(posedge clk);
    cyc++;
    model_edge(v, l, c);
    #1;
    check("model", dut_obs(), m_exp);
  endtask

  vec_t tbl[16];
  int   long_at, long_n;
  int   rpt_got[$];
  int   rpt_exp[$];

  initial begin
    rst_n = 1'b0; sw_valid = 1'b0; sw_level = 1'b0; cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_obs(), obs_t'(0));
    rst_n = 1'b1;

    // Short press/release, ignored toggles, duplicates, clear
    tbl[0]  = mk(1, 1, 0, 1, 0, 0, 1, 1);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 1, 1);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 1, 1);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 1, 1);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 1, 1);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 1, 1);
    tbl[6]  = mk(1, 0, 0, 0, 1, 0, 0, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0, 1);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 1);
    tbl[10] = mk(1, 1, 1, 1, 0, 0, 1, 1);
    tbl[11] = mk(1, 1, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1);
    tbl[13] = mk(1, 1, 0, 0, 0, 0, 0, 1);
    tbl[14] = mk(1, 0, 0, 0, 1, 0, 0, 1);
    tbl[15] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].l, tbl[i].c);
      check($sformatf("table[%0d]", i), dut_obs(), tbl[i].exp);
    end

    // Long press and auto-repeat timing relative to the press pulse
    step(1, 1, 0);
    long_at = -1; long_n = 0;
    for (int i = 1; i <= 36; i++) begin
      step(0, 1, 0);
      if (long_press) begin long_at = i; long_n++; end
      if (repeat_evt) rpt_got.push_back(i);
      if (RPT_EN && i > LONG && ((i - LONG) % RPT) == 0) rpt_exp.push_back(i);
    end
    check_int("long_press_offset", long_at, LONG);
    check_int("long_press_count", long_n, 1);
    check_int("repeat_count", rpt_got.size(), rpt_exp.size());
    for (int i = 0; i < rpt_got.size() && i < rpt_exp.size(); i++)
      check_int($sformatf("repeat_offset[%0d]", i), rpt_got[i], rpt_exp[i]);
    step(1, 0, 0);
    check_int("release_after_long", int'(release_evt), 1);

    // Release exactly when the hold would reach the long-press point
    step(1, 1, 0);
    for (int i = 1; i < LONG; i++) step(0, 1, 0);
    step(1, 0, 0);
    check_int("boundary_release", int'(release_evt), 1);
    check_int("boundary_no_long", int'(long_press), 0);
    step(0, 0, 0);
    check_int("boundary_no_late_long", int'(long_press), 0);

    // Counter wrap after 16 presses, then clear coinciding with a press
    step(0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0);
      step(1, 0, 0);
    end
    check_int("count_wrap", int'(press_count), 0);
    step(1, 1, 1);
    check_int("clr_with_press", int'(press_count), 1);
    step(1, 0, 0);

    // Level toggles without valid, then a duplicate press while held
    for (int i = 0; i < 6; i++) step(0, logic'(i % 2), 0);
    check_int("toggle_no_count", int'(press_count), 1);
    step(1, 1, 0);
    step(1, 1, 0);
    check_int("dup_no_press", int'(press), 0);
    check_int("dup_count", int'(press_count), 2);
    step(1, 0, 0);
    check_int("dup_release", int'(release_evt), 1);

    // Asynchronous reset in the middle of a hold
    step(1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    rst_n = 1'b0;
    #2;
    check("async_reset_mid_hold", dut_obs(), obs_t'(0));
    repeat (2) @(posedge clk);
    #1;
    sw_valid = 1'b0; sw_level = 1'b0; cnt_clr = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(1, 0, 0);
    check_int("post_reset_no_release", int'(release_evt), 0);
    step(1, 1, 0);
    check_int("post_reset_first_press", int'(press_count), 1);
    step(1, 0, 0);

    // Random traffic: alternate busy and sparse valid phases so long holds occur
    for (int i = 0; i < 800; i++) begin
      logic v;
      if ((i / 100) % 2 == 0) v = ($urandom_range(0, 2) == 0);
      else                     v = ($urandom_range(0, 39) == 0);
      step(v, logic'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
